// File: rtl/rv_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_boot_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader (state encoding, word and header geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package rv_boot_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned HDR_WIDTH  = 16;

    typedef enum logic [2:0] {
        HDR_LO  = 3'd0,
        HDR_HI  = 3'd1,
        DATA    = 3'd2,
        CSUM    = 3'd3,
        RELEASE = 3'd4,
        RUN     = 3'd5,
        ERROR   = 3'd6
    } boot_state_e;

endpackage
`default_nettype wire

// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader_if
// Description : Byte-stream input, instruction-memory write port and core
//               reset/status lines of the boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_boot_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;

    // master: the loader itself; slave: byte source, memory and core side
    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
    );

endinterface
`default_nettype wire

// File: rtl/imem_boot_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader_byte_packer
// Description : Packs bytes LSB-first into 32-bit words; pulses o_word_valid
//               for one cycle with the registered word after the 4th byte.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader_byte_packer (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_byte_valid,
    input  wire logic [7:0]  i_byte_data,
    output logic             o_lane_full,
    output logic             o_word_valid,
    output logic [31:0]      o_word
);

    logic [1:0]  r_idx_q, w_idx_d;
    logic [23:0] r_shreg_q, w_shreg_d;
    logic        r_word_valid_q, w_word_valid_d;
    logic [31:0] r_word_q, w_word_d;

    always_comb begin
        w_idx_d        = r_idx_q;
        w_shreg_d      = r_shreg_q;
        w_word_valid_d = 1'b0;
        w_word_d       = r_word_q;
        if (i_byte_valid) begin
            // Right shift leaves bytes 0..2 in [7:0],[15:8],[23:16] after three pushes
            w_shreg_d = {i_byte_data, r_shreg_q[23:8]};
            w_idx_d   = r_idx_q + 2'd1;
            if (r_idx_q == 2'd3) begin
                w_word_valid_d = 1'b1;
                w_word_d       = {i_byte_data, r_shreg_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx_q        <= 2'd0;
            r_shreg_q      <= 24'd0;
            r_word_valid_q <= 1'b0;
            r_word_q       <= 32'd0;
        end else begin
            r_idx_q        <= w_idx_d;
            r_shreg_q      <= w_shreg_d;
            r_word_valid_q <= w_word_valid_d;
            r_word_q       <= w_word_d;
        end
    end

    assign o_lane_full  = (r_idx_q == 2'd3);
    assign o_word_valid = r_word_valid_q;
    assign o_word       = r_word_q;

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Loads a length-prefixed byte stream into instruction memory
//               while holding the core in reset, then releases it.
//               Optional trailing XOR checksum: IMEM_BOOT_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
    import rv_boot_pkg::*;
#(
    parameter int unsigned IMEM_WORDS     = 64,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    imem_boot_loader_if.master bus
);

    localparam int unsigned          c_REL_W     = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [c_REL_W-1:0]   c_REL_LAST  = c_REL_W'(RELEASE_CYCLES - 1);
    localparam logic [HDR_WIDTH-1:0] c_MAX_WORDS = HDR_WIDTH'(IMEM_WORDS);

    boot_state_e          r_state_q, w_state_d;
    logic                 r_in_ready_q, w_in_ready_d;
    logic [7:0]           r_hdr_lo_q, w_hdr_lo_d;
    logic [HDR_WIDTH-1:0] r_n_q, w_n_d;
    logic [HDR_WIDTH-1:0] r_word_cnt_q, w_word_cnt_d;
    logic [c_REL_W-1:0]   r_rel_cnt_q, w_rel_cnt_d;
    logic [31:0]          r_addr_q, w_addr_d;
    logic                 r_core_rst_q, w_core_rst_d;
    logic                 r_done_q, w_done_d;
    logic                 r_err_q, w_err_d;

    logic                 w_xfer, w_data_byte, w_lane_full, w_word_valid;
    logic [31:0]          w_word;
    logic [HDR_WIDTH-1:0] w_n_hdr;

    assign w_xfer      = bus.in_valid && r_in_ready_q;
    assign w_data_byte = w_xfer && (r_state_q == DATA);
    assign w_n_hdr     = {bus.in_data, r_hdr_lo_q};

    imem_boot_loader_byte_packer u_byte_packer (
        .clk          (clk),
        .rst          (rst),
        .i_byte_valid (w_data_byte),
        .i_byte_data  (bus.in_data),
        .o_lane_full  (w_lane_full),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0] r_csum_q, w_csum_d;
    assign w_csum_d = (w_xfer && (r_state_q != CSUM)) ? (r_csum_q ^ bus.in_data) : r_csum_q;
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_hdr_lo_d   = r_hdr_lo_q;
        w_n_d        = r_n_q;
        w_word_cnt_d = r_word_cnt_q;
        w_rel_cnt_d  = r_rel_cnt_q;
        w_core_rst_d = r_core_rst_q;
        w_done_d     = r_done_q;
        w_err_d      = r_err_q;
        // Address advances in the cycle after the write strobe it accompanied
        w_addr_d     = w_word_valid ? (r_addr_q + 32'(WORD_BYTES)) : r_addr_q;
        case (r_state_q)
            HDR_LO: if (w_xfer) begin
                w_hdr_lo_d = bus.in_data;
                w_state_d  = HDR_HI;
            end
            HDR_HI: if (w_xfer) begin
                w_n_d = w_n_hdr;
                if (w_n_hdr == '0) begin
                    w_state_d   = RELEASE;
                    w_rel_cnt_d = '0;
                end else if (w_n_hdr > c_MAX_WORDS) begin
                    w_state_d = ERROR;
                    w_err_d   = 1'b1;
                end else begin
                    w_state_d = DATA;
                end
            end
            DATA: if (w_xfer && w_lane_full) begin
                w_word_cnt_d = r_word_cnt_q + 1'b1;
                if (r_word_cnt_q == (r_n_q - 1'b1)) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    w_state_d   = CSUM;
`else
                    w_state_d   = RELEASE;
                    w_rel_cnt_d = '0;
`endif
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            CSUM: if (w_xfer) begin
                if (bus.in_data == r_csum_q) begin
                    w_state_d   = RELEASE;
                    w_rel_cnt_d = '0;
                end else begin
                    w_state_d = ERROR;
                    w_err_d   = 1'b1;
                end
            end
`endif
            RELEASE: begin
                if (r_rel_cnt_q == c_REL_LAST) begin
                    w_state_d    = RUN;
                    w_core_rst_d = 1'b0;
                    w_done_d     = 1'b1;
                end else begin
                    w_rel_cnt_d = r_rel_cnt_q + 1'b1;
                end
            end
            RUN, ERROR: ;
            default: w_state_d = ERROR;
        endcase
        w_in_ready_d = (w_state_d == HDR_LO) || (w_state_d == HDR_HI) ||
                       (w_state_d == DATA)   || (w_state_d == CSUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= HDR_LO;
            r_in_ready_q <= 1'b0;
            r_hdr_lo_q   <= 8'd0;
            r_n_q        <= '0;
            r_word_cnt_q <= '0;
            r_rel_cnt_q  <= '0;
            r_addr_q     <= BASE_ADDR;
            r_core_rst_q <= 1'b1;
            r_done_q     <= 1'b0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_in_ready_q <= w_in_ready_d;
            r_hdr_lo_q   <= w_hdr_lo_d;
            r_n_q        <= w_n_d;
            r_word_cnt_q <= w_word_cnt_d;
            r_rel_cnt_q  <= w_rel_cnt_d;
            r_addr_q     <= w_addr_d;
            r_core_rst_q <= w_core_rst_d;
            r_done_q     <= w_done_d;
            r_err_q      <= w_err_d;
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) r_csum_q <= 8'd0;
        else     r_csum_q <= w_csum_d;
    end
`endif

    assign bus.in_ready   = r_in_ready_q;
    assign bus.imem_we    = w_word_valid;
    assign bus.imem_addr  = r_addr_q;
    assign bus.imem_wdata = w_word;
    assign bus.core_rst   = r_core_rst_q;
    assign bus.done       = r_done_q;
    assign bus.err        = r_err_q;

endmodule
`default_nettype wire
